vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; successor to the fixed 640x480 xy controller.
- Runs entirely in the CLOCK_50 domain, using a pixel-tick clock enable instead of an internally derived clock.
- Provides:
  - scaled dot coordinates with a request/return latency contract;
  - frame and line strobes;
  - delay-matched sync, blank and colour outputs.
- Sits between the game/framebuffer logic and the board DAC.

Parameters:
- CLK_DIV, 2: CLOCK_50 cycles per pixel tick (1..15).
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch.
- H_SYNC, 96: horizontal sync width.
- H_BP, 48: horizontal back porch.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch.
- V_SYNC, 2: vertical sync width.
- V_BP, 33: vertical back porch.
- HS_POL, 0: active level of VGA_HS.
- VS_POL, 0: active level of VGA_VS.
- SCALE_SHIFT, 1: dot = pixel >> SCALE_SHIFT (0..3).
- BPC, 1: colour bits per channel (1..10).
- PIX_LAT, 1: pixel ticks from x/y to the matching color input (0..7).

Ports:
- CLOCK_50  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- color  in  3*BPC  {R,G,B} for the dot requested PIX_LAT ticks earlier.
- x  out  11  dot column, = hcount >> SCALE_SHIFT.
- y  out  11  dot row, = vcount >> SCALE_SHIFT.
- active  out  1  x/y lies in the visible area.
- pix_tick  out  1  one-cycle pixel enable.
- frame_start  out  1  pulse on the tick where hcount=0, vcount=0.
- line_start  out  1  pulse on every tick where hcount=0.
- VGA_R/VGA_G/VGA_B  out  10 each  DAC colour.
- VGA_HS, VGA_VS  out  1  syncs.
- VGA_BLANK  out  1  high = visible (DAC convention).
- VGA_SYNC  out  1  constant 1.
- VGA_CLK  out  1  pixel clock to DAC; high for the first floor(CLK_DIV/2) cycles of each tick period.

Behaviour:
- Reset (async, resetn=0):
  - div counter, hcount and vcount = 0;
  - x=y=0, active=0, pix_tick=0, frame_start=0, line_start=0;
  - VGA_R/G/B=0, VGA_BLANK=0, VGA_CLK=0;
  - VGA_HS=~HS_POL, VGA_VS=~VS_POL;
  - delay pipeline cleared to the same blank/inactive values.
  - Reset mid-frame aborts the frame. After release, the first pix_tick occurs CLK_DIV cycles later with frame_start=1.
- Divider: counts 0..CLK_DIV-1. pix_tick=1 in the cycle the count equals CLK_DIV-1. With CLK_DIV=1, pix_tick is constantly 1 after reset and VGA_CLK is driven as the inverted CLOCK_50 gate-free register output; document that the board is only supported for CLK_DIV>=2.
- Counters advance only on pix_tick:
  - hcount wraps at H_TOTAL-1 to 0 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP);
  - vcount increments on the hcount wrap and wraps at V_TOTAL-1.
  - On the simultaneous hcount/vcount wrap, both go to 0 and the next tick raises frame_start.
- x, y, active, frame_start and line_start are registered from the counters on the same tick, so they are valid from the tick after the counter update until the next tick.
- Sync/blank, per tick:
  - hs_raw active when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC;
  - vs_raw active likewise on vertical;
  - blank_raw = active.
- Delay pipeline: these raw values pass through a PIX_LAT+1 stage shift register clocked on pix_tick.
- Colour register: on each tick VGA_R/G/B register the expanded color, forced to 0 when the delayed blank is low. Net effect: colour, VGA_HS, VGA_VS and VGA_BLANK for a given x/y appear together exactly PIX_LAT+1 ticks after x/y.
- Colour expansion: each channel's BPC bits are replicated MSB-first across 10 bits, truncated at the LSB end. Example, BPC=3, value 101: 1011011011.
- Parameter checks: illegal values (SCALE_SHIFT>3, H_TOTAL>2048, PIX_LAT>7) stop elaboration via a generate-time error.

Optional Feature:
- Macro VGA_TEST_PATTERN_EN.
- When defined, adds input test_mode (1 bit). While test_mode=1, color is ignored and replaced by 8 vertical bars: bar index = hcount*8/H_ACTIVE, channel bits {R,G,B} = bar index bits {2,1,0}, each replicated to BPC bits. The pattern is delay-matched identically to color.
- When undefined, there is no test_mode port and no pattern logic.

Decomposition:
- Package vga_pkg holds:
  - standard timing constant sets (VGA_640x480_60, VGA_800x600_60);
  - function expand_chan(value, bpc) returning 10 bits;
  - localparam helpers H_TOTAL/V_TOTAL.
- One sub-module, vga_delay_line: parametrised width and depth shift register with enable and async reset value, used for the sync/blank pipeline.

Test Plan:
- Reset release, defaults: first frame_start 2 cycles after release; 800 ticks between line_starts; 420000 ticks between frame_starts.
- Horizontal sync: VGA_HS low for exactly 96 ticks, starting 1+PIX_LAT+1 ticks after the tick where hcount=656. VGA_VS is low for 2 lines (1600 ticks).
- Scaling: SCALE_SHIFT=2, so x holds each value for 4 ticks, x max 159, y max 119. SCALE_SHIFT=0 gives x max 639.
- Latency alignment: PIX_LAT=3, bench returns color = x[2:0] delayed 3 ticks. Every visible VGA_R/G/B word must match expand(x) of the dot, and must be 0 whenever VGA_BLANK=0.
- Colour expansion: BPC=3, color=9'b101_011_000 gives VGA_R=1011011011, VGA_G=0110110110, VGA_B=0.
- Reset mid-frame (at vcount=200): all outputs return to reset values within 0 cycles. frame_start is seen again 2 cycles after release.
- VGA_TEST_PATTERN_EN with test_mode=1: bar 5 (hcount 400..479) outputs R=all ones, G=0, B=all ones.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing presets, line-total helpers and colour channel expansion
// for the vga_timing_gen raster generator.
package vga_pkg;

  typedef struct packed {
    logic [11:0] h_active;
    logic [11:0] h_fp;
    logic [11:0] h_sync;
    logic [11:0] h_bp;
    logic [11:0] v_active;
    logic [11:0] v_fp;
    logic [11:0] v_sync;
    logic [11:0] v_bp;
  } vga_timing_t;

  localparam vga_timing_t VGA_640x480_60 = '{12'd640, 12'd16, 12'd96, 12'd48,
                                             12'd480, 12'd10, 12'd2, 12'd33};
  localparam vga_timing_t VGA_800x600_60 = '{12'd800, 12'd40, 12'd128, 12'd88,
                                             12'd600, 12'd1, 12'd4, 12'd23};

  function automatic int line_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int h_total(input vga_timing_t t);
    return line_total(int'(t.h_active), int'(t.h_fp), int'(t.h_sync), int'(t.h_bp));
  endfunction

  function automatic int v_total(input vga_timing_t t);
    return line_total(int'(t.v_active), int'(t.v_fp), int'(t.v_sync), int'(t.v_bp));
  endfunction

  localparam int VGA_640x480_H_TOTAL = h_total(VGA_640x480_60);
  localparam int VGA_640x480_V_TOTAL = v_total(VGA_640x480_60);

  // Replicates the low bpc bits of value MSB-first across 10 bits; the last
  // copy is truncated at the LSB end.
  function automatic logic [9:0] expand_chan(input logic [9:0] value, input int bpc);
    logic [9:0] res;
    logic [9:0] sh;
    res = '0;
    for (int i = 0; i < 10; i++) begin
      sh = value >> (bpc - 1 - (i % bpc));
      res[9 - i] = sh[0];
    end
    return res;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enabled shift register of configurable width and depth; DEPTH=0 is a wire.
module vga_delay_line import vga_pkg::*; #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    assign dout = din;
  end else begin : g_shift
    logic [WIDTH-1:0] stages [DEPTH];

    // NOTE: every stage is reset, not just the tail: the contents feed sync
    // outputs directly and must come up inactive after a mid-frame abort.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
        for (int i = 0; i < DEPTH; i++) stages[i] <= RST_VAL;
      end else if (en) begin
        stages[0] <= din;
        for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
      end
    end

    assign dout = stages[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator on a CLOCK_50 pixel-tick enable.
// Optional `VGA_TEST_PATTERN_EN adds a test_mode input selecting 8 colour bars.
// The board DAC path is only supported for CLK_DIV >= 2.
module vga_timing_gen import vga_pkg::*; #(
  parameter int CLK_DIV     = 2,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int SCALE_SHIFT = 1,
  parameter int BPC         = 1,
  parameter int PIX_LAT     = 1
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
`ifdef VGA_TEST_PATTERN_EN
  input  logic             test_mode,
`endif
  input  logic [3*BPC-1:0] color,
  output logic [10:0]      x,
  output logic [10:0]      y,
  output logic             active,
  output logic             pix_tick,
  output logic             frame_start,
  output logic             line_start,
  output logic [9:0]       VGA_R,
  output logic [9:0]       VGA_G,
  output logic [9:0]       VGA_B,
  output logic             VGA_HS,
  output logic             VGA_VS,
  output logic             VGA_BLANK,
  output logic             VGA_SYNC,
  output logic             VGA_CLK
);

  localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (SCALE_SHIFT > 3 || H_TOTAL > 2048 || V_TOTAL > 2048 || PIX_LAT > 7 ||
      CLK_DIV < 1 || CLK_DIV > 15 || BPC < 1 || BPC > 10) begin : g_bad_params
    $error("vga_timing_gen: illegal parameter set");
  end

  localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [3:0]  DIV_HALF = 4'(CLK_DIV / 2);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [11:0] H_VIS    = 12'(H_ACTIVE);
  localparam logic [11:0] V_VIS    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [3:0]  div_cnt, div_nxt;
  logic        tick;
  logic [10:0] hcount, vcount;
  logic        hs_q, vs_q;

  assign tick    = (div_cnt == DIV_LAST);
  assign div_nxt = tick ? 4'd0 : div_cnt + 4'd1;

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      div_cnt  <= '0;
      pix_tick <= 1'b0;
    end else begin
      div_cnt  <= div_nxt;
      pix_tick <= tick;
    end
  end

  if (CLK_DIV == 1) begin : g_clk_bypass
    // A divided clock cannot exist here; the DAC gets CLOCK_50 inverted once running.
    logic run_q;
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) run_q <= 1'b0;
      else         run_q <= 1'b1;
    end
    assign VGA_CLK = run_q & ~CLOCK_50;
  end else begin : g_clk_div
    logic clk_q;
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) clk_q <= 1'b0;
      else         clk_q <= (div_nxt < DIV_HALF);
    end
    assign VGA_CLK = clk_q;
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int DL_W = 6;
  logic [2:0] bar_q, bar_d;
`else
  localparam int DL_W = 3;
`endif

  // Raster counters; the dot outputs capture the pre-update counter values.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      hcount      <= '0;
      vcount      <= '0;
      x           <= '0;
      y           <= '0;
      active      <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
`ifdef VGA_TEST_PATTERN_EN
      bar_q       <= '0;
`endif
    end else if (tick) begin
      x           <= hcount >> SCALE_SHIFT;
      y           <= vcount >> SCALE_SHIFT;
      active      <= ({1'b0, hcount} < H_VIS) && ({1'b0, vcount} < V_VIS);
      frame_start <= (hcount == '0) && (vcount == '0);
      line_start  <= (hcount == '0);
      hs_q        <= ({1'b0, hcount} >= HS_START) && ({1'b0, hcount} < HS_END);
      vs_q        <= ({1'b0, vcount} >= VS_START) && ({1'b0, vcount} < VS_END);
`ifdef VGA_TEST_PATTERN_EN
      bar_q       <= 3'((32'(hcount) * 8) / H_ACTIVE);
`endif
      if (hcount == H_LAST) begin
        hcount <= '0;
        vcount <= (vcount == V_LAST) ? '0 : vcount + 11'd1;
      end else begin
        hcount <= hcount + 11'd1;
      end
    end
  end

  logic [DL_W-1:0] dl_din, dl_dout;
  logic            hs_d, vs_d, blank_d;

`ifdef VGA_TEST_PATTERN_EN
  assign dl_din = {hs_q, vs_q, active, bar_q};
  assign {hs_d, vs_d, blank_d, bar_d} = dl_dout;
`else
  assign dl_din = {hs_q, vs_q, active};
  assign {hs_d, vs_d, blank_d} = dl_dout;
`endif

  // PIX_LAT stages here plus the output register below give PIX_LAT+1 in total.
  vga_delay_line #(
    .WIDTH   (DL_W),
    .DEPTH   (PIX_LAT),
    .RST_VAL ('0)
  ) u_delay (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .en       (tick),
    .din      (dl_din),
    .dout     (dl_dout)
  );

  logic [9:0] r_exp, g_exp, b_exp;

  // NOTE: defaults are assigned first so no path leaves a channel unassigned.
  always_comb begin
    r_exp = expand_chan(10'(color[3*BPC-1 -: BPC]), BPC);
    g_exp = expand_chan(10'(color[2*BPC-1 -: BPC]), BPC);
    b_exp = expand_chan(10'(color[BPC-1:0]), BPC);
`ifdef VGA_TEST_PATTERN_EN
    if (test_mode) begin
      r_exp = {10{bar_d[2]}};
      g_exp = {10{bar_d[1]}};
      b_exp = {10{bar_d[0]}};
    end
`endif
  end

  logic hs_o, vs_o;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      hs_o      <= 1'b0;
      vs_o      <= 1'b0;
      VGA_BLANK <= 1'b0;
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
    end else if (tick) begin
      hs_o      <= hs_d;
      vs_o      <= vs_d;
      VGA_BLANK <= blank_d;
      VGA_R     <= blank_d ? r_exp : '0;
      VGA_G     <= blank_d ? g_exp : '0;
      VGA_B     <= blank_d ? b_exp : '0;
    end
  end

  assign VGA_HS   = hs_o ? HS_POL : ~HS_POL;
  assign VGA_VS   = vs_o ? VS_POL : ~VS_POL;
  assign VGA_SYNC = 1'b1;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster: random colours against a
// tick-indexed arithmetic reference model, plus reset and latency checks.
module tb_vga_timing_gen;

  localparam int  CLK_DIV = 2;
  localparam int  HA = 32, HFP = 4, HSW = 6, HBP = 6;
  localparam int  VA = 12, VFP = 2, VSW = 2, VBP = 3;
  localparam int  HT = HA + HFP + HSW + HBP;
  localparam int  VT = VA + VFP + VSW + VBP;
  localparam int  S  = 2;
  localparam int  BPC = 3;
  localparam int  L  = 3;
  localparam int  MAXD = 4096;

  logic             CLOCK_50 = 1'b0;
  logic             resetn   = 1'b0;
  logic [3*BPC-1:0] color    = '0;
`ifdef VGA_TEST_PATTERN_EN
  logic             test_mode = 1'b0;
`endif
  logic [10:0] x, y;
  logic        active, pix_tick, frame_start, line_start;
  logic [9:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, VGA_CLK;

  vga_timing_gen #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .SCALE_SHIFT(S), .BPC(BPC), .PIX_LAT(L)
  ) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .color(color), .x(x), .y(y), .active(active), .pix_tick(pix_tick),
    .frame_start(frame_start), .line_start(line_start),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK(VGA_BLANK), .VGA_SYNC(VGA_SYNC), .VGA_CLK(VGA_CLK)
  );

  initial forever #10 CLOCK_50 = ~CLOCK_50;

  int   checks = 0;
  int   errors = 0;
  logic [8:0] col_mem [0:MAXD-1];
  bit         tm_mem  [0:MAXD-1];
  bit         tm_now = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference expansion: concatenate whole copies, keep the top 10 bits.
  function automatic logic [9:0] model_expand(input logic [9:0] v, input int bpc);
    longint rep = 0;
    int     n   = (10 + bpc - 1) / bpc;
    for (int k = 0; k < n; k++) rep = (rep << bpc) | longint'(v);
    return 10'(rep >> (n * bpc - 10));
  endfunction

  task automatic check_reset_vals();
    check("rst_x", 32'(x), 0);
    check("rst_y", 32'(y), 0);
    check("rst_active", 32'(active), 0);
    check("rst_pix_tick", 32'(pix_tick), 0);
    check("rst_frame_start", 32'(frame_start), 0);
    check("rst_line_start", 32'(line_start), 0);
    check("rst_rgb", {2'b0, VGA_R, VGA_G, VGA_B}, 0);
    check("rst_blank", 32'(VGA_BLANK), 0);
    check("rst_vga_clk", 32'(VGA_CLK), 0);
    check("rst_hs", 32'(VGA_HS), 1);
    check("rst_vs", 32'(VGA_VS), 1);
  endtask

  // Period p is the p-th pixel period since reset release.
  task automatic check_period(input int p);
    int h, v, od, oh, ov;
    bit vis, hs_on, vs_on;
    logic [9:0] er, eg, eb;
    h = p % HT;
    v = (p / HT) % VT;
    check("pix_tick", 32'(pix_tick), 1);
    check("vga_clk_high", 32'(VGA_CLK), 1);
    check("vga_sync", 32'(VGA_SYNC), 1);
    check("x", 32'(x), h >> S);
    check("y", 32'(y), v >> S);
    check("active", 32'(active), (h < HA && v < VA) ? 1 : 0);
    check("frame_start", 32'(frame_start), (h == 0 && v == 0) ? 1 : 0);
    check("line_start", 32'(line_start), (h == 0) ? 1 : 0);
    od = p - (L + 1);
    vis = 1'b0; hs_on = 1'b0; vs_on = 1'b0; er = '0; eg = '0; eb = '0;
    oh = 0;
    if (od >= 0) begin
      oh = od % HT;
      ov = (od / HT) % VT;
      vis   = (oh < HA) && (ov < VA);
      hs_on = (oh >= HA + HFP) && (oh < HA + HFP + HSW);
      vs_on = (ov >= VA + VFP) && (ov < VA + VFP + VSW);
      if (vis) begin
        if (tm_mem[od]) begin
          er = {10{((oh / (HA / 8)) >> 2) & 1 ? 1'b1 : 1'b0}};
          eg = {10{((oh / (HA / 8)) >> 1) & 1 ? 1'b1 : 1'b0}};
          eb = {10{(oh / (HA / 8)) & 1 ? 1'b1 : 1'b0}};
        end else begin
          er = model_expand(10'(col_mem[od][8:6]), BPC);
          eg = model_expand(10'(col_mem[od][5:3]), BPC);
          eb = model_expand(10'(col_mem[od][2:0]), BPC);
        end
      end
    end
    check("vga_hs", 32'(VGA_HS), hs_on ? 0 : 1);
    check("vga_vs", 32'(VGA_VS), vs_on ? 0 : 1);
    check("vga_blank", 32'(VGA_BLANK), vis ? 1 : 0);
    check("vga_r", 32'(VGA_R), 32'(er));
    check("vga_g", 32'(VGA_G), 32'(eg));
    check("vga_b", 32'(VGA_B), 32'(eb));
    if (vis && oh == 5 && !tm_mem[od]) begin
      check("expand_r_101", 32'(VGA_R), 32'b1011011011);
      check("expand_g_011", 32'(VGA_G), 32'b0110110110);
      check("expand_b_000", 32'(VGA_B), 0);
    end
    if (vis && tm_mem[od] && oh >= 20 && oh < 24) begin
      check("bar5_r", 32'(VGA_R), 32'h3ff);
      check("bar5_g", 32'(VGA_G), 0);
      check("bar5_b", 32'(VGA_B), 32'h3ff);
    end
  endtask

  // Colour driven in period p answers the dot shown PIX_LAT periods earlier.
  task automatic drive_color(input int p);
    int q;
    logic [8:0] c;
    q = p - L;
    c = 9'($urandom);
    if (q >= 0) begin
      if (q % HT == 5) c = 9'b101_011_000;
      col_mem[q] = c;
      tm_mem[q]  = tm_now;
    end
`ifdef VGA_TEST_PATTERN_EN
    test_mode = tm_now;
`endif
    color = c;
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 16; i++) begin
      @(negedge CLOCK_50);
      if (pix_tick) return;
      check("vga_clk_low", 32'(VGA_CLK), 0);
    end
    checks++;
    assert (pix_tick === 1'b1) else begin
      errors++;
      $error("FAIL tick_timeout: got pix_tick=%b, expected 1 within 16 cycles", pix_tick);
    end
  endtask

  task automatic release_and_first_tick();
    int n;
    @(negedge CLOCK_50);
    resetn = 1'b1;
    n = 0;
    do begin
      @(negedge CLOCK_50);
      n++;
    end while (!pix_tick && n < 16);
    check("first_tick_cycles", n, CLK_DIV);
    check_period(0);
    drive_color(0);
  endtask

  initial begin
    int seg1;
    resetn = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check_reset_vals();

    release_and_first_tick();
    seg1 = 2 * HT * VT + 7 * HT + 10;
    for (int p = 1; p <= seg1; p++) begin
      wait_tick();
      check_period(p);
      drive_color(p);
    end

    // Abort mid-frame (line 7 of the third frame) with an asynchronous reset.
    #2 resetn = 1'b0;
    #1 check_reset_vals();
    repeat (2) @(negedge CLOCK_50);
    check_reset_vals();

    release_and_first_tick();
    for (int p = 1; p <= 1000; p++) begin
`ifdef VGA_TEST_PATTERN_EN
      tm_now = (p >= 300 && p < 700);
`endif
      wait_tick();
      check_period(p);
      drive_color(p);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
